fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the byte-addressed instruction memory.
- Owns the program counter and drives it onto the memory's read address.
- Captures the returned 32-bit big-endian instruction word into an IF/ID pipeline register for the decode stage.
- Handles sequential advance with wrap-around, stall, flush and taken-branch/jump redirect.

---
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage placed directly in front of a byte-addressed,
// combinational-read instruction memory. It owns the program counter, presents
// it to memory and captures the returned word into the IF/ID register.
//
// Ports
//   clk            in   1   single clock, rising edge
//   rst            in   1   synchronous active-high reset
//   pc_addr        out  32  current PC (registered), instruction memory address
//   imem_data      in   32  instruction word for pc_addr (same cycle)
//   stall          in   1   hold PC and IF/ID
//   flush          in   1   invalidate IF/ID (PC unaffected)
//   branch_taken   in   1   redirect fetch to branch_target
//   branch_target  in   32  redirect byte address
//   if_id_instr    out  32  instruction for decode
//   if_id_pc       out  32  PC of if_id_instr
//   if_id_pc4      out  32  if_id_pc + 4 (not wrapped)
//   if_id_valid    out  1   IF/ID holds a real instruction
//   misalign_err   out  1   sticky: some redirect target was not word aligned
//   fetch_count    out  32  instructions accepted into IF/ID since reset
//
// Control semantics: there is no valid/ready handshake here. Each rising edge
// the PC obeys branch_taken > stall > advance, and IF/ID independently obeys
// (flush | branch_taken) > stall > load. fetch_count steps only on a load.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int          MEM_BYTES = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  // MEM_BYTES is a power of two, so modulo reduces to an AND mask.
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  logic [31:0] pc_q,          pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q,    if_id_pc_d;
  logic [31:0] if_id_pc4_q,   if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misalign_q,    misalign_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic        redirect_misaligned;

  assign pc_plus4            = pc_q + 32'd4;
  assign redirect_misaligned = branch_taken && (branch_target[1:0] != 2'b00);

  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;

    // PC: a redirect wins even over stall; target is aligned down, then masked.
    if (branch_taken) begin
      pc_d = {branch_target[31:2], 2'b00} & ADDR_MASK;
    end else if (!stall) begin
      pc_d = pc_plus4 & ADDR_MASK;
    end

    // IF/ID: the word currently being fetched is on the wrong path when we
    // redirect, so it is squashed exactly like a flush. pc/pc4 keep old values.
    if (flush || branch_taken) begin
      if_id_instr_d = NOP;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      if_id_instr_d = imem_data;
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_plus4;
      if_id_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end

    if (redirect_misaligned) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP;
      if_id_pc_q    <= 32'd0;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_addr      = pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_pc4    = if_id_pc4_q;
  assign if_id_valid  = if_id_valid_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage: directed, table-driven bench for fetch_stage with a small
// 8-word instruction memory model (MEM_BYTES = 32, RESET_PC = 0, NOP = 0).
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP_W = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [31:0] pc_addr, imem_data, branch_target;
  logic        stall, flush, branch_taken;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4, fetch_count;
  logic        if_id_valid, misalign_err;

  fetch_stage #(.MEM_BYTES(32), .RESET_PC(32'h0), .NOP(NOP_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_addr      (pc_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  // ---------------- instruction memory model ----------------
  logic [31:0] mem [8];
  assign imem_data = mem[pc_addr[4:2]];

  function automatic logic [31:0] w(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall, flush, br;
    logic [31:0] tgt;
    logic [31:0] pc, instr, ipc, ipc4;
    logic        valid, mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic s, input logic f, input logic b,
                              input logic [31:0] tgt, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] ipc,
                              input logic [31:0] ipc4, input logic v,
                              input logic m, input logic [31:0] c);
    vec_t r;
    r.stall = s; r.flush = f; r.br = b; r.tgt = tgt;
    r.pc = pc; r.instr = instr; r.ipc = ipc; r.ipc4 = ipc4;
    r.valid = v; r.mis = m; r.cnt = c;
    return r;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic cmp32(input string name, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", name, fld, act, exp);
    end
  endtask

  task automatic check(input string name, input vec_t e);
    n_vec++;
    cmp32(name, "pc_addr",      pc_addr,             e.pc);
    cmp32(name, "if_id_instr",  if_id_instr,         e.instr);
    cmp32(name, "if_id_pc",     if_id_pc,            e.ipc);
    cmp32(name, "if_id_pc4",    if_id_pc4,           e.ipc4);
    cmp32(name, "if_id_valid",  {31'd0, if_id_valid},  {31'd0, e.valid});
    cmp32(name, "misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
    cmp32(name, "fetch_count",  fetch_count,         e.cnt);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic s, input logic f,
                       input logic b, input logic [31:0] tgt);
    rst = r; stall = s; flush = f; branch_taken = b; branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  vec_t rst_exp;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = w(i);

    // Free run: edge k leaves pc = 4k mod 32 and IF/ID holding word k-1.
    for (int k = 1; k <= 10; k++) begin
      logic [31:0] ipc;
      ipc = 32'((4 * (k - 1)) % 32);
      vecs.push_back(mk(0, 0, 0, 0, 32'((4 * k) % 32), w((k - 1) % 8),
                        ipc, ipc + 32'd4, 1, 0, 32'(k)));
    end
    // Stall three cycles at pc=8: everything frozen on W1 / pc 4.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0, 0, 0, 32'h08, w(1), 32'h04, 32'h08, 1, 0, 32'd10));
    // Release: W2 loads.
    vecs.push_back(mk(0, 0, 0, 0, 32'h0C, w(2), 32'h08, 32'h0C, 1, 0, 32'd11));
    // Redirect to 0x14: IF/ID squashed, pc/pc4 held.
    vecs.push_back(mk(0, 0, 1, 32'h14, 32'h14, NOP_W, 32'h08, 32'h0C, 0, 0, 32'd11));
    vecs.push_back(mk(0, 0, 0, 0, 32'h18, w(5), 32'h14, 32'h18, 1, 0, 32'd12));
    // Misaligned out-of-range redirect while stalled: 0x2E -> 0x2C & 0x1F = 0x0C.
    vecs.push_back(mk(1, 0, 1, 32'h2E, 32'h0C, NOP_W, 32'h14, 32'h18, 0, 1, 32'd12));
    vecs.push_back(mk(0, 0, 0, 0, 32'h10, w(3), 32'h0C, 32'h10, 1, 1, 32'd13));
    // Flush with stall: PC held, IF/ID invalidated, count frozen.
    vecs.push_back(mk(1, 1, 0, 0, 32'h10, NOP_W, 32'h0C, 32'h10, 0, 1, 32'd13));
    // Flush alone: PC advances, IF/ID invalidated.
    vecs.push_back(mk(0, 1, 0, 0, 32'h14, NOP_W, 32'h0C, 32'h10, 0, 1, 32'd13));
    vecs.push_back(mk(0, 0, 0, 0, 32'h18, w(5), 32'h14, 32'h18, 1, 1, 32'd14));
    // Aligned out-of-range target 0x104 masks silently to 0x04.
    vecs.push_back(mk(0, 0, 1, 32'h104, 32'h04, NOP_W, 32'h14, 32'h18, 0, 1, 32'd14));
    vecs.push_back(mk(0, 0, 0, 0, 32'h08, w(1), 32'h04, 32'h08, 1, 1, 32'd15));
    // Redirect to last word, then wrap: pc4 is not wrapped (0x20).
    vecs.push_back(mk(0, 0, 1, 32'h1C, 32'h1C, NOP_W, 32'h04, 32'h08, 0, 1, 32'd15));
    vecs.push_back(mk(0, 0, 0, 0, 32'h00, w(7), 32'h1C, 32'h20, 1, 1, 32'd16));
    // Redirect with flush asserted too.
    vecs.push_back(mk(0, 1, 1, 32'h10, 32'h10, NOP_W, 32'h1C, 32'h20, 0, 1, 32'd16));
    vecs.push_back(mk(0, 0, 0, 0, 32'h14, w(4), 32'h10, 32'h14, 1, 1, 32'd17));

    rst_exp = mk(0, 0, 0, 0, 32'h0, NOP_W, 32'h0, 32'h0, 0, 0, 32'd0);

    // ---- reset ----
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("reset", rst_exp);

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt);
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // ---- reset during stall + misaligned redirect: reset wins ----
    drive(1, 1, 1, 1, 32'h13);
    check("rst_mid_redirect", rst_exp);
    // First valid instruction is W0 one edge after reset drops.
    drive(0, 0, 0, 0, 0);
    check("post_rst_first", mk(0, 0, 0, 0, 32'h04, w(0), 32'h0, 32'h04, 1, 0, 32'd1));

    // ---- misalign with in-range target while not stalled, then stays ----
    drive(0, 0, 0, 1, 32'h09);
    check("misalign_09", mk(0, 0, 0, 0, 32'h08, NOP_W, 32'h0, 32'h04, 0, 1, 32'd1));
    drive(0, 0, 0, 0, 0);
    check("misalign_sticky", mk(0, 0, 0, 0, 32'h0C, w(2), 32'h08, 32'h0C, 1, 1, 32'd2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
